// File: rtl/vga_timing_gen_pkg.sv
// Shared 640x480@60 timing constants and raster helper types for the Pong display pipeline.
// Hit stages import this package for screen bounds.
package vga_timing_gen_pkg;

  localparam int CLK_DIV_DEF    = 4;
  localparam int H_ACTIVE_DEF   = 640;
  localparam int H_FP_DEF       = 16;
  localparam int H_SYNC_DEF     = 96;
  localparam int H_BP_DEF       = 48;
  localparam int V_ACTIVE_DEF   = 480;
  localparam int V_FP_DEF       = 10;
  localparam int V_SYNC_DEF     = 2;
  localparam int V_BP_DEF       = 33;
  localparam int SYNC_DELAY_DEF = 1;

  localparam int H_TOTAL_DEF = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
  localparam int V_TOTAL_DEF = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

  // Undelayed raster decode carried through the alignment delay line.
  typedef struct packed {
    logic hs;
    logic vs;
    logic act;
  } raw_sync_t;

  localparam int SYNC_W = $bits(raw_sync_t);

  function automatic logic in_window(input logic [9:0] cnt, input int lo, input int len);
    return (int'(cnt) >= lo) && (int'(cnt) < lo + len);
  endfunction

endpackage

// File: rtl/vga_timing_gen_pipe_delay.sv
// Fixed-depth clocked shift register with synchronous reset to RESET_VAL.
// DEPTH=0 degenerates to a wire that still forces RESET_VAL while reset is high.
module vga_timing_gen_pipe_delay #(
  parameter int                 WIDTH     = 3,
  parameter int                 DEPTH     = 1,
  parameter logic [WIDTH-1:0]   RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  localparam int N = (DEPTH == 0) ? 1 : DEPTH;

  logic [WIDTH-1:0] sr_q [N];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < N; i++) sr_q[i] <= RESET_VAL;
    end else begin
      sr_q[0] <= d_i;
      for (int i = 1; i < N; i++) sr_q[i] <= sr_q[i-1];
    end
  end

  assign q_o = (DEPTH == 0) ? (reset ? RESET_VAL : d_i) : sr_q[N-1];

endmodule

// File: rtl/vga_timing_gen.sv
// Raster timing source: pixel strobe, poll coordinates, delayed sync/blanking and FrameTick.
// Sync outputs are delayed to line up with the one-clock registered hit stages downstream.
module vga_timing_gen
  import vga_timing_gen_pkg::*;
#(
  parameter int   CLK_DIV    = CLK_DIV_DEF,
  parameter int   H_ACTIVE   = H_ACTIVE_DEF,
  parameter int   H_FP       = H_FP_DEF,
  parameter int   H_SYNC     = H_SYNC_DEF,
  parameter int   H_BP       = H_BP_DEF,
  parameter int   V_ACTIVE   = V_ACTIVE_DEF,
  parameter int   V_FP       = V_FP_DEF,
  parameter int   V_SYNC     = V_SYNC_DEF,
  parameter int   V_BP       = V_BP_DEF,
  parameter int   SYNC_DELAY = SYNC_DELAY_DEF,
  parameter logic HS_POL     = 1'b0,
  parameter logic VS_POL     = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  output logic       PixelEn,
  output logic [9:0] PollX,
  output logic [8:0] PollY,
  output logic       Active,
  output logic       ActiveD,
  output logic       HSync,
  output logic       VSync,
  output logic       FrameTick
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  generate
    if (H_TOTAL > 1024 || V_ACTIVE > 512 || V_TOTAL > 1024 ||
        CLK_DIV < 1 || CLK_DIV > 16 || SYNC_DELAY < 0 || SYNC_DELAY > 7) begin : g_bad_params
      $error("vga_timing_gen: illegal timing parameters");
    end
  endgenerate

  localparam logic [3:0] DIV_LAST   = 4'(CLK_DIV - 1);
  localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
  localparam logic [9:0] V_ACT_LAST = 10'(V_ACTIVE - 1);

  logic [3:0] div_cnt_q, div_cnt_d;
  logic [9:0] hcnt_q, hcnt_d;
  logic [9:0] vcnt_q, vcnt_d;
  logic       frame_tick_q, frame_tick_d;
  logic       pixel_en;
  logic       h_active, v_active;
  raw_sync_t  raw_sync;
  raw_sync_t  dly_sync;

  always_comb begin
    pixel_en     = (div_cnt_q == DIV_LAST) && !reset;
    div_cnt_d    = (div_cnt_q == DIV_LAST) ? 4'd0 : div_cnt_q + 4'd1;
    hcnt_d       = hcnt_q;
    vcnt_d       = vcnt_q;
    frame_tick_d = pixel_en && (hcnt_q == H_LAST) && (vcnt_q == V_ACT_LAST);
    if (pixel_en) begin
      if (hcnt_q == H_LAST) begin
        hcnt_d = 10'd0;
        vcnt_d = (vcnt_q == V_LAST) ? 10'd0 : vcnt_q + 10'd1;
      end else begin
        hcnt_d = hcnt_q + 10'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt_q    <= 4'd0;
      hcnt_q       <= 10'd0;
      vcnt_q       <= 10'd0;
      frame_tick_q <= 1'b0;
    end else begin
      div_cnt_q    <= div_cnt_d;
      hcnt_q       <= hcnt_d;
      vcnt_q       <= vcnt_d;
      frame_tick_q <= frame_tick_d;
    end
  end

  // Coordinate decode: purely from registered counters, so glitch-free.
  always_comb begin
    h_active     = int'(hcnt_q) < H_ACTIVE;
    v_active     = int'(vcnt_q) < V_ACTIVE;
    raw_sync.hs  = in_window(hcnt_q, H_ACTIVE + H_FP, H_SYNC);
    raw_sync.vs  = in_window(vcnt_q, V_ACTIVE + V_FP, V_SYNC);
    raw_sync.act = h_active && v_active;
  end

  assign PollX  = h_active ? hcnt_q : 10'd0;
  assign PollY  = v_active ? vcnt_q[8:0] : 9'd0;
  assign Active = raw_sync.act;

  vga_timing_gen_pipe_delay #(
    .WIDTH     (SYNC_W),
    .DEPTH     (SYNC_DELAY),
    .RESET_VAL ('0)
  ) u_sync_dly (
    .clk   (clk),
    .reset (reset),
    .d_i   (raw_sync),
    .q_o   (dly_sync)
  );

  assign HSync     = dly_sync.hs ? HS_POL : ~HS_POL;
  assign VSync     = dly_sync.vs ? VS_POL : ~VS_POL;
  assign ActiveD   = dly_sync.act;
  assign PixelEn   = pixel_en;
  assign FrameTick = frame_tick_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: three instances (default 640x480, two small rasters) checked
// every clock against an arithmetic raster model under random reset pulses.
module tb_vga_timing_gen;

  localparam int P_CDIV[3] = '{4, 1, 3};
  localparam int P_HA[3]   = '{640, 16, 20};
  localparam int P_HF[3]   = '{16, 2, 3};
  localparam int P_HS[3]   = '{96, 4, 5};
  localparam int P_HB[3]   = '{48, 3, 4};
  localparam int P_VA[3]   = '{480, 6, 8};
  localparam int P_VF[3]   = '{10, 1, 2};
  localparam int P_VS[3]   = '{2, 2, 3};
  localparam int P_VB[3]   = '{33, 2, 4};
  localparam int P_SD[3]   = '{1, 0, 3};
  localparam bit P_HP[3]   = '{1'b0, 1'b1, 1'b0};
  localparam bit P_VP[3]   = '{1'b0, 1'b0, 1'b1};

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       pe[3];
  logic [9:0] px[3];
  logic [8:0] py[3];
  logic       act[3], actd[3], hs[3], vs[3], ft[3];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    vga_timing_gen #(
      .CLK_DIV(P_CDIV[g]), .H_ACTIVE(P_HA[g]), .H_FP(P_HF[g]), .H_SYNC(P_HS[g]),
      .H_BP(P_HB[g]), .V_ACTIVE(P_VA[g]), .V_FP(P_VF[g]), .V_SYNC(P_VS[g]),
      .V_BP(P_VB[g]), .SYNC_DELAY(P_SD[g]), .HS_POL(P_HP[g]), .VS_POL(P_VP[g])
    ) u_dut (
      .clk       (clk),
      .reset     (reset),
      .PixelEn   (pe[g]),
      .PollX     (px[g]),
      .PollY     (py[g]),
      .Active    (act[g]),
      .ActiveD   (actd[g]),
      .HSync     (hs[g]),
      .VSync     (vs[g]),
      .FrameTick (ft[g])
    );
  end

  int total = 0;
  int bad   = 0;

  // Reference state: clocks elapsed since reset release, and raw decodes pushed per clock.
  longint   n[3];
  bit [2:0] hist[3][8];
  bit       ftx[3];

  task automatic chk(input string tag, input int k, input int got, input int exp_v);
    total++;
    if (got != exp_v) begin
      bad++;
      $display("FAIL %s[dut%0d] got=%0d expected=%0d (t=%0t)", tag, k, got, exp_v, $time);
    end
  endtask

  function automatic int htot(input int k);
    return P_HA[k] + P_HF[k] + P_HS[k] + P_HB[k];
  endfunction

  function automatic int vtot(input int k);
    return P_VA[k] + P_VF[k] + P_VS[k] + P_VB[k];
  endfunction

  function automatic void locate(input int k, input longint nn, output int h, output int v);
    longint pix;
    pix = (nn / P_CDIV[k]) % longint'(htot(k) * vtot(k));
    h = int'(pix % htot(k));
    v = int'(pix / htot(k));
  endfunction

  function automatic bit [2:0] raw_of(input int k, input int h, input int v);
    bit hsr, vsr, ar;
    hsr = (h >= P_HA[k] + P_HF[k]) && (h < P_HA[k] + P_HF[k] + P_HS[k]);
    vsr = (v >= P_VA[k] + P_VF[k]) && (v < P_VA[k] + P_VF[k] + P_VS[k]);
    ar  = (h < P_HA[k]) && (v < P_VA[k]);
    return {hsr, vsr, ar};
  endfunction

  task automatic check_all();
    for (int k = 0; k < 3; k++) begin
      int h, v;
      bit [2:0] r;
      bit pe_x;
      locate(k, n[k], h, v);
      pe_x = !reset && (n[k] % P_CDIV[k] == P_CDIV[k] - 1);
      if (P_SD[k] == 0) r = reset ? 3'b000 : raw_of(k, h, v);
      else              r = hist[k][P_SD[k]-1];
      chk("PixelEn",   k, int'(pe[k]),   int'(pe_x));
      chk("PollX",     k, int'(px[k]),   (h < P_HA[k]) ? h : 0);
      chk("PollY",     k, int'(py[k]),   (v < P_VA[k]) ? v : 0);
      chk("Active",    k, int'(act[k]),  int'((h < P_HA[k]) && (v < P_VA[k])));
      chk("HSync",     k, int'(hs[k]),   int'(r[2] ? P_HP[k] : !P_HP[k]));
      chk("VSync",     k, int'(vs[k]),   int'(r[1] ? P_VP[k] : !P_VP[k]));
      chk("ActiveD",   k, int'(actd[k]), int'(r[0]));
      chk("FrameTick", k, int'(ft[k]),   int'(ftx[k]));
    end
  endtask

  task automatic edge_update(input bit r_in);
    for (int k = 0; k < 3; k++) begin
      int h, v;
      longint nn;
      locate(k, n[k], h, v);
      if (r_in) begin
        for (int i = 0; i < 8; i++) hist[k][i] = 3'b000;
        n[k]   = 0;
        ftx[k] = 1'b0;
      end else begin
        for (int i = 7; i > 0; i--) hist[k][i] = hist[k][i-1];
        hist[k][0] = raw_of(k, h, v);
        nn = n[k] + 1;
        ftx[k] = (nn % P_CDIV[k] == 0) &&
                 ((nn / P_CDIV[k]) % longint'(htot(k) * vtot(k)) == longint'(P_VA[k] * htot(k)));
        n[k] = nn;
      end
    end
  endtask

  // Called just after a falling edge: check, drive reset for the next rising edge, advance.
  task automatic tick(input bit r_in);
    check_all();
    reset = r_in;
    @(posedge clk);
    edge_update(r_in);
    @(negedge clk);
  endtask

  int first_pe = -1;
  int f1 = -1;
  int f2 = -1;
  int hsw = -1;
  bit prev_hs = 1'b1;

  initial begin
    for (int k = 0; k < 3; k++) begin
      n[k] = 0;
      ftx[k] = 1'b0;
      for (int i = 0; i < 8; i++) hist[k][i] = 3'b000;
    end
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    repeat (4) tick(1'b1);

    for (int c = 0; c < 7000; c++) begin
      tick(1'b0);
      if (first_pe < 0 && pe[0]) first_pe = int'(n[0]) + 1;
      if (prev_hs && !hs[0]) begin
        if (f1 < 0) f1 = int'(n[0]);
        else if (f2 < 0) f2 = int'(n[0]);
      end
      if (!prev_hs && hs[0] && hsw < 0 && f1 >= 0) hsw = int'(n[0]) - f1;
      prev_hs = hs[0];
    end
    chk("first_pixel_en_clk", 0, first_pe, 4);
    chk("hsync_low_width", 0, hsw, 384);
    chk("hsync_fall_period", 0, (f2 >= 0 && f1 >= 0) ? f2 - f1 : -1, 3200);

    for (int s = 0; s < 40; s++) begin
      repeat ($urandom_range(1, 3)) tick(1'b1);
      repeat ($urandom_range(50, 1500)) tick(1'b0);
    end
    repeat (3000) tick(1'b0);
    check_all();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
